core_multiphase_controller: RTL and testbench
=============================================

CORE_MULTIPHASE_CONTROLLER -- requirements
Module: core_multiphase_controller

Interface
REQ-001 Parameter MAX_PHASES, default 2, is the maximum number of EXEC/MEM phase pairs per instruction; legal range 2..16.
REQ-002 Parameter PHASE_W, default $clog2(MAX_PHASES), is the width of the phase index; it is derived and never overridden.
REQ-003 clk  input  1  core clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 fetch_stage_valid  output  1  FETCH stage enable.
REQ-006 fetch_stage_ready  input  1  FETCH stage done.
REQ-007 exec_stage_valid  output  1  EXEC stage enable.
REQ-008 exec_stage_ready  input  1  EXEC stage done.
REQ-009 exec_phase  output  PHASE_W  index of the current phase, for the EXEC and MEM stages.
REQ-010 phase_has_mem  input  1  from decode: the current phase has a MEM step; valid during EXEC and MEM.
REQ-011 phase_last  input  1  from decode: the current phase is the final phase; valid during EXEC and MEM.
REQ-012 wb_phase  input  PHASE_W  from decode: the phase whose completion writes rd.
REQ-013 mem_stage_valid  output  1  MEM stage enable.
REQ-014 mem_stage_ready  input  1  MEM stage done.
REQ-015 trap_req  input  1  exception raised by the EXEC or MEM stage; qualified by that stage's ready.
REQ-016 trap_valid  output  1  trap handler request.
REQ-017 trap_ready  input  1  trap handler done.
REQ-018 reg_d_en  output  1  register-file write enable, one cycle.
REQ-019 retire  output  1  one-cycle pulse when an instruction completes without a trap.
REQ-020 phase_overflow  output  1  one-cycle pulse when a trap is forced by phase overflow (REQ-027).

Function
REQ-021 The state machine SHALL have the states IDLE, FETCH, EXEC, MEM and TRAP, plus a phase counter ph of width PHASE_W.
REQ-022 IDLE SHALL transition to FETCH unconditionally.
REQ-023 FETCH SHALL transition to EXEC with ph=0 when fetch_stage_ready is high, and SHALL hold otherwise.
REQ-024 EXEC SHALL hold while exec_stage_ready is low; when it is high, the next state SHALL be:
- TRAP if trap_req is high;
- otherwise MEM if phase_has_mem is high;
- otherwise FETCH if phase_last is high;
- otherwise EXEC with ph+1.
REQ-025 MEM SHALL hold while mem_stage_ready is low; when it is high, the next state SHALL be:
- TRAP if trap_req is high;
- otherwise FETCH if phase_last is high;
- otherwise EXEC with ph+1.
REQ-026 TRAP SHALL hold while trap_ready is low and SHALL transition to FETCH when trap_ready is high.
REQ-027 Phase overflow: at a phase end (REQ-029) with ph==MAX_PHASES-1, phase_last low and trap_req low, the next state SHALL be TRAP and phase_overflow SHALL pulse; ph never wraps.
REQ-028 Stage outputs SHALL be decoded from state only:
- fetch_stage_valid = FETCH;
- exec_stage_valid = EXEC;
- mem_stage_valid = MEM;
- trap_valid = TRAP;
- exec_phase = ph.
REQ-029 A phase end SHALL be either:
- EXEC with exec_stage_ready high and phase_has_mem low; or
- MEM with mem_stage_ready high.
REQ-030 reg_d_en SHALL be combinational and high in a phase-end cycle iff ph==wb_phase and trap_req is low.
REQ-031 retire SHALL be high in a phase-end cycle iff phase_last is high and trap_req is low.
REQ-032 A trap SHALL suppress reg_d_en for the trapping phase only; writes from earlier phases stand.
REQ-033 ph SHALL be cleared on entry to FETCH and to TRAP.
REQ-034 Single-cycle stages: back-to-back ready is allowed, so each state lasts a minimum of 1 cycle.

Reset
REQ-035 While rst_n is low, state SHALL be IDLE and ph SHALL be 0.
REQ-036 While rst_n is low, all outputs SHALL be 0, including exec_phase.
REQ-037 Reset asserted mid-instruction SHALL abandon it with no reg_d_en or retire.
REQ-038 The first cycle after reset release SHALL be IDLE, then FETCH.

Structure
REQ-039 The state enum (ctrl_state_e) SHALL be placed in core_pkg alongside the existing ctrl_path_e.
REQ-040 The constant CORE_MAX_PHASES (default 2) SHALL be placed in core_pkg.
REQ-041 The block SHALL be a single module with no sub-module; the decode-side inputs replace the internal ctrl_path decode.

Verification (MAX_PHASES=4)
REQ-042 ALU op: phase_has_mem=0, phase_last=1, wb_phase=0, all readies high -> FETCH,EXEC,FETCH; reg_d_en and retire high in the EXEC cycle.
REQ-043 AMO: phase 0 has mem, phase 1 has mem and is last, wb_phase=0 -> exec_phase 0,0,1,1 across EXEC,MEM,EXEC,MEM; reg_d_en at the end of MEM ph0; retire at the end of MEM ph1.
REQ-044 Stalls: mem_stage_ready low for 3 cycles -> MEM held 4 cycles, outputs stable, exactly one reg_d_en.
REQ-045 trap_req with mem_stage_ready in phase 1 -> TRAP with no reg_d_en or retire; trap_ready after 2 cycles -> FETCH; exec_phase=0.
REQ-046 phase_last never high over 4 phases -> TRAP after ph=3 completes, phase_overflow pulses once, no retire.
REQ-047 rst_n low during MEM ph1 -> all outputs 0 immediately; IDLE then FETCH after release.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core control types: datapath selection and the multiphase controller state encoding.
package core_pkg;

  localparam int CORE_MAX_PHASES = 2;

  typedef enum logic [1:0] {
    PATH_ALU,
    PATH_LOAD,
    PATH_STORE,
    PATH_AMO
  } ctrl_path_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_TRAP
  } ctrl_state_e;

endpackage

// File: rtl/core_multiphase_controller.sv
// Sequences FETCH -> (EXEC [MEM])* -> FETCH for instructions split into up to MAX_PHASES phases,
// with trap handling and a forced trap when an instruction runs out of phases.
module core_multiphase_controller
  import core_pkg::*;
#(
  parameter int MAX_PHASES = CORE_MAX_PHASES,
  parameter int PHASE_W    = $clog2(MAX_PHASES)
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               fetch_stage_valid,
  input  logic               fetch_stage_ready,
  output logic               exec_stage_valid,
  input  logic               exec_stage_ready,
  output logic [PHASE_W-1:0] exec_phase,
  input  logic               phase_has_mem,
  input  logic               phase_last,
  input  logic [PHASE_W-1:0] wb_phase,
  output logic               mem_stage_valid,
  input  logic               mem_stage_ready,
  input  logic               trap_req,
  output logic               trap_valid,
  input  logic               trap_ready,
  output logic               reg_d_en,
  output logic               retire,
  output logic               phase_overflow
);

  localparam logic [PHASE_W-1:0] PH_LAST = PHASE_W'(MAX_PHASES - 1);

  ctrl_state_e        state, state_nx;
  logic [PHASE_W-1:0] ph, ph_nx;
  logic               phase_end, ph_at_max;

  // A phase ends when its final stage completes: EXEC without MEM, or MEM.
  assign phase_end = (state == ST_EXEC && exec_stage_ready && !phase_has_mem) ||
                     (state == ST_MEM  && mem_stage_ready);
  assign ph_at_max = (ph == PH_LAST);

  assign reg_d_en       = phase_end && (ph == wb_phase) && !trap_req;
  assign retire         = phase_end && phase_last && !trap_req;
  assign phase_overflow = phase_end && !trap_req && !phase_last && ph_at_max;

  assign exec_phase = ph;

  always_comb begin
    state_nx = state;
    ph_nx    = ph;
    unique case (state)
      ST_IDLE: begin
        state_nx = ST_FETCH;
        ph_nx    = '0;
      end
      ST_FETCH: begin
        if (fetch_stage_ready) begin
          state_nx = ST_EXEC;
          ph_nx    = '0;
        end
      end
      ST_EXEC, ST_MEM: begin
        if ((state == ST_EXEC && exec_stage_ready) || (state == ST_MEM && mem_stage_ready)) begin
          if (trap_req) begin
            state_nx = ST_TRAP;
            ph_nx    = '0;
          end else if (state == ST_EXEC && phase_has_mem) begin
            state_nx = ST_MEM;
          end else if (phase_last) begin
            state_nx = ST_FETCH;
            ph_nx    = '0;
          end else if (ph_at_max) begin
            // No phase left to advance into: trap instead of wrapping.
            state_nx = ST_TRAP;
            ph_nx    = '0;
          end else begin
            state_nx = ST_EXEC;
            ph_nx    = ph + PHASE_W'(1);
          end
        end
      end
      ST_TRAP: begin
        if (trap_ready) begin
          state_nx = ST_FETCH;
          ph_nx    = '0;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        ph_nx    = '0;
      end
    endcase
  end

  // Stage enables are registered copies of the state decode so they come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      ph                <= '0;
      fetch_stage_valid <= 1'b0;
      exec_stage_valid  <= 1'b0;
      mem_stage_valid   <= 1'b0;
      trap_valid        <= 1'b0;
    end else begin
      state             <= state_nx;
      ph                <= ph_nx;
      fetch_stage_valid <= (state_nx == ST_FETCH);
      exec_stage_valid  <= (state_nx == ST_EXEC);
      mem_stage_valid   <= (state_nx == ST_MEM);
      trap_valid        <= (state_nx == ST_TRAP);
    end
  end

endmodule

// File: tb/tb_core_multiphase_controller.sv
// Directed tests for core_multiphase_controller with MAX_PHASES=4.
module tb_core_multiphase_controller;

  localparam int MP = 4;
  localparam int PW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_stage_valid, fetch_stage_ready;
  logic          exec_stage_valid, exec_stage_ready;
  logic [PW-1:0] exec_phase;
  logic          phase_has_mem, phase_last;
  logic [PW-1:0] wb_phase;
  logic          mem_stage_valid, mem_stage_ready;
  logic          trap_req, trap_valid, trap_ready;
  logic          reg_d_en, retire, phase_overflow;

  int total = 0;
  int bad   = 0;

  core_multiphase_controller #(.MAX_PHASES(MP)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_stage_valid(fetch_stage_valid), .fetch_stage_ready(fetch_stage_ready),
    .exec_stage_valid(exec_stage_valid), .exec_stage_ready(exec_stage_ready),
    .exec_phase(exec_phase), .phase_has_mem(phase_has_mem), .phase_last(phase_last),
    .wb_phase(wb_phase), .mem_stage_valid(mem_stage_valid), .mem_stage_ready(mem_stage_ready),
    .trap_req(trap_req), .trap_valid(trap_valid), .trap_ready(trap_ready),
    .reg_d_en(reg_d_en), .retire(retire), .phase_overflow(phase_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Packs all outputs: {fetch,exec,mem,trap,phase[1:0],reg_d_en,retire,overflow}
  function automatic logic [8:0] outs();
    return {fetch_stage_valid, exec_stage_valid, mem_stage_valid, trap_valid,
            exec_phase, reg_d_en, retire, phase_overflow};
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    fetch_stage_ready = 0; exec_stage_ready = 0; mem_stage_ready = 0; trap_ready = 0;
    phase_has_mem = 0; phase_last = 0; wb_phase = 0; trap_req = 0;
    tick;
    total++; if (outs() !== 9'h0) begin bad++; $display("FAIL reset_outs got=%h want=0", outs()); end
    #2 rst_n = 1'b1;
    #1;
    total++; if (fetch_stage_valid !== 1'b0) begin bad++; $display("FAIL reset_idle fetch=%b want=0", fetch_stage_valid); end
    tick;
    total++; if (fetch_stage_valid !== 1'b1) begin bad++; $display("FAIL reset_fetch fetch=%b want=1", fetch_stage_valid); end
  endtask

  task automatic test_alu;
    phase_has_mem = 0; phase_last = 1; wb_phase = 0; exec_stage_ready = 1; fetch_stage_ready = 1;
    #1;
    total++; if (fetch_stage_valid !== 1'b1) begin bad++; $display("FAIL alu_fetch got=%b want=1", fetch_stage_valid); end
    tick; fetch_stage_ready = 0; #1;
    total++; if (outs() !== 9'b0100_00_110) begin bad++; $display("FAIL alu_exec got=%b want=010000110", outs()); end
    tick; #1;
    total++; if (outs() !== 9'b1000_00_000) begin bad++; $display("FAIL alu_back got=%b want=100000000", outs()); end
  endtask

  task automatic test_amo;
    phase_has_mem = 1; phase_last = 0; wb_phase = 0;
    exec_stage_ready = 1; mem_stage_ready = 1; fetch_stage_ready = 1;
    tick; fetch_stage_ready = 0; #1;
    total++; if (outs() !== 9'b0100_00_000) begin bad++; $display("FAIL amo_exec0 got=%b want=010000000", outs()); end
    tick; #1;
    total++; if (outs() !== 9'b0010_00_100) begin bad++; $display("FAIL amo_mem0 got=%b want=001000100", outs()); end
    tick; phase_last = 1; #1;
    total++; if (outs() !== 9'b0100_01_000) begin bad++; $display("FAIL amo_exec1 got=%b want=010001000", outs()); end
    tick; #1;
    total++; if (outs() !== 9'b0010_01_010) begin bad++; $display("FAIL amo_mem1 got=%b want=001001010", outs()); end
    tick; #1;
    total++; if (outs() !== 9'b1000_00_000) begin bad++; $display("FAIL amo_fetch got=%b want=100000000", outs()); end
  endtask

  task automatic test_stall;
    int wr = 0;
    phase_has_mem = 1; phase_last = 1; wb_phase = 0;
    exec_stage_ready = 1; mem_stage_ready = 0; fetch_stage_ready = 1;
    tick; fetch_stage_ready = 0;
    tick;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_stage_ready = 1;
      #1;
      total++;
      if (outs() !== {4'b0010, 2'b00, (i == 3) ? 1'b1 : 1'b0, (i == 3) ? 1'b1 : 1'b0, 1'b0}) begin
        bad++; $display("FAIL stall_mem%0d got=%b", i, outs());
      end
      if (reg_d_en) wr++;
      tick;
    end
    #1;
    total++; if (fetch_stage_valid !== 1'b1) begin bad++; $display("FAIL stall_fetch got=%b want=1", fetch_stage_valid); end
    total++; if (wr !== 1) begin bad++; $display("FAIL stall_writes got=%0d want=1", wr); end
  endtask

  task automatic test_trap;
    phase_has_mem = 1; phase_last = 0; wb_phase = 1; trap_req = 0;
    exec_stage_ready = 1; mem_stage_ready = 1; fetch_stage_ready = 1;
    tick; fetch_stage_ready = 0;
    tick; #1;
    total++; if (reg_d_en !== 1'b0) begin bad++; $display("FAIL trap_mem0_wr got=%b want=0", reg_d_en); end
    tick; phase_last = 1;
    tick; trap_req = 1; #1;
    total++; if (outs() !== 9'b0010_01_000) begin bad++; $display("FAIL trap_mem1 got=%b want=001001000", outs()); end
    tick; trap_req = 0; trap_ready = 0; #1;
    total++; if (outs() !== 9'b0001_00_000) begin bad++; $display("FAIL trap_enter got=%b want=000100000", outs()); end
    tick; #1;
    total++; if (trap_valid !== 1'b1) begin bad++; $display("FAIL trap_hold got=%b want=1", trap_valid); end
    tick; trap_ready = 1; #1;
    total++; if (trap_valid !== 1'b1) begin bad++; $display("FAIL trap_hold2 got=%b want=1", trap_valid); end
    tick; trap_ready = 0; #1;
    total++; if (outs() !== 9'b1000_00_000) begin bad++; $display("FAIL trap_exit got=%b want=100000000", outs()); end
  endtask

  task automatic test_overflow;
    int ovf = 0;
    phase_has_mem = 0; phase_last = 0; wb_phase = 2;
    exec_stage_ready = 1; fetch_stage_ready = 1;
    tick; fetch_stage_ready = 0;
    for (int p = 0; p < 4; p++) begin
      #1;
      total++;
      if (outs() !== {4'b0100, PW'(p), (p == 2) ? 1'b1 : 1'b0, 1'b0, (p == 3) ? 1'b1 : 1'b0}) begin
        bad++; $display("FAIL ovf_exec%0d got=%b", p, outs());
      end
      if (phase_overflow) ovf++;
      tick;
    end
    #1;
    total++; if (outs() !== 9'b0001_00_000) begin bad++; $display("FAIL ovf_trap got=%b want=000100000", outs()); end
    total++; if (ovf !== 1) begin bad++; $display("FAIL ovf_pulses got=%0d want=1", ovf); end
    trap_ready = 1;
    tick; trap_ready = 0; #1;
    total++; if (fetch_stage_valid !== 1'b1) begin bad++; $display("FAIL ovf_fetch got=%b want=1", fetch_stage_valid); end
  endtask

  task automatic test_reset_mid;
    phase_has_mem = 1; phase_last = 0; wb_phase = 0;
    exec_stage_ready = 1; mem_stage_ready = 1; fetch_stage_ready = 1;
    tick; fetch_stage_ready = 0;
    tick;
    tick; phase_last = 1; mem_stage_ready = 0;
    tick; #1;
    total++; if (outs() !== 9'b0010_01_000) begin bad++; $display("FAIL rmid_mem1 got=%b want=001001000", outs()); end
    rst_n = 1'b0; mem_stage_ready = 1; #1;
    total++; if (outs() !== 9'h0) begin bad++; $display("FAIL rmid_outs got=%b want=0", outs()); end
    tick;
    total++; if (outs() !== 9'h0) begin bad++; $display("FAIL rmid_hold got=%b want=0", outs()); end
    rst_n = 1'b1; #1;
    total++; if (outs() !== 9'h0) begin bad++; $display("FAIL rmid_idle got=%b want=0", outs()); end
    tick;
    total++; if (outs() !== 9'b1000_00_000) begin bad++; $display("FAIL rmid_fetch got=%b want=100000000", outs()); end
  endtask

  initial begin
    test_reset;
    test_alu;
    test_amo;
    test_stall;
    test_trap;
    test_overflow;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
